acq_ctrl: RTL and testbench

Acquisition controller for the oscilloscope capture path. It selects the sample timebase for the clock divider and latches that choice for the length of each capture. It writes ADC samples into a ring-buffer RAM on each sample strobe and detects the trigger with a configurable pre-trigger depth and auto-trigger timeout. A handshake with the display side hands over each completed record.

---
 rtl/acq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_acq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_ctrl.sv
// acq_ctrl: oscilloscope acquisition controller. Latches the timebase for
// each capture, writes ADC samples into a ring buffer on every sample
// strobe, finds the trigger (edge or auto timeout) and hands the finished
// record to the display side.
//
// Hand-off: ready is the "valid" side of the record hand-off. It rises when
// a complete record sits in the buffer and stays high until the display
// pulses disp_ack; the record is considered consumed on the in_clk edge
// that samples ready=1 and disp_ack=1 together. disp_ack while ready=0 is
// ignored, and stop withdraws ready without any acknowledge.
module acq_ctrl #(
  parameter int DEPTH_LOG2 = 8,
  parameter int PRE_DEPTH  = 64,
  parameter int AUTO_TICKS = 1024
) (
  input  logic                  in_clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [7:0]            adc_data,
  input  logic [1:0]            tb_sel,
  input  logic                  arm,
  input  logic                  stop,
  input  logic                  single,
  input  logic                  auto_mode,
  input  logic [7:0]            trig_level,
  input  logic                  trig_rising,
  input  logic                  disp_ack,
  output logic [1:0]            divisor,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic                  busy,
  output logic                  ready,
  output logic                  forced,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READY = 3'd4
  } state_t;

  localparam int TO_W = $clog2(AUTO_TICKS + 1);
  // Counter values seen on the last write of the PRE and POST phases.
  localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'((1 << DEPTH_LOG2) - PRE_DEPTH - 2);
  localparam logic [TO_W-1:0]       TO_MAX    = TO_W'(AUTO_TICKS);

  state_t                  state, state_nxt;
  logic [DEPTH_LOG2-1:0]   wp;
  logic [DEPTH_LOG2-1:0]   pre_cnt;
  logic [DEPTH_LOG2-1:0]   post_cnt;
  logic [TO_W-1:0]         to_cnt;
  logic [7:0]              prev;
  logic                    hit;
  logic                    do_wr;
  logic                    clr;
  logic                    trig_now;
  logic                    trig_forced;

  assign state_dbg = state;

  // State register.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, write enable, capture clear and trigger decision.
  always_comb begin
    state_nxt   = state;
    do_wr       = 1'b0;
    clr         = 1'b0;
    trig_now    = 1'b0;
    trig_forced = 1'b0;
    hit         = trig_rising ? ((prev < trig_level) && (adc_data >= trig_level))
                              : ((prev > trig_level) && (adc_data <= trig_level));
    if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) begin
            state_nxt = S_PRE;
            clr       = 1'b1;
          end
        end
        S_PRE: begin
          if (sample_tick) begin
            do_wr = 1'b1;
            if (pre_cnt == PRE_LAST) state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (sample_tick) begin
            do_wr = 1'b1;
            // A real edge takes priority over the timeout on the same tick.
            if (hit) begin
              trig_now  = 1'b1;
              state_nxt = S_POST;
            end else if (auto_mode && (to_cnt == TO_MAX)) begin
              trig_now    = 1'b1;
              trig_forced = 1'b1;
              state_nxt   = S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_tick) begin
            do_wr = 1'b1;
            if (post_cnt == POST_LAST) state_nxt = S_READY;
          end
        end
        S_READY: begin
          if (disp_ack) begin
            clr       = ~single;
            state_nxt = single ? S_IDLE : S_PRE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: write port, pointer, phase counters, trigger record, status.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      to_cnt    <= '0;
      prev      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      trig_addr <= '0;
      forced    <= 1'b0;
      divisor   <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      wr_en <= do_wr;
      if (clr) begin
        wp       <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        to_cnt   <= '0;
        forced   <= 1'b0;
      end
      if (do_wr) begin
        wr_addr <= wp;
        wr_data <= adc_data;
        wp      <= wp + 1'b1;
        prev    <= adc_data;
        if (state == S_PRE)  pre_cnt  <= pre_cnt + 1'b1;
        if (state == S_POST) post_cnt <= post_cnt + 1'b1;
        // Saturate so normal mode can sit in ARMED forever.
        if ((state == S_ARMED) && !trig_now && (to_cnt != TO_MAX))
          to_cnt <= to_cnt + 1'b1;
      end
      if (trig_now) begin
        trig_addr <= wp;
        forced    <= trig_forced;
      end
      // Timebase only tracks the request between captures.
      if (state == S_IDLE) divisor <= tb_sel;
      busy  <= (state_nxt == S_PRE) || (state_nxt == S_ARMED) || (state_nxt == S_POST);
      ready <= (state_nxt == S_READY);
    end
  end

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl: small buffer (16 samples, 4 pre-trigger,
// auto timeout 8 ticks), sample strobe every 5 clocks.
module tb_acq_ctrl;

  localparam int D = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_ARMED = 3'd2,
                         ST_POST = 3'd3, ST_READY = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic [7:0] adc_data = '0;
  logic [1:0] tb_sel = '0;
  logic       arm = 1'b0, stop = 1'b0, single = 1'b1, auto_mode = 1'b0;
  logic [7:0] trig_level = 8'h80;
  logic       trig_rising = 1'b1, disp_ack = 1'b0;
  logic [1:0] divisor;
  logic       wr_en;
  logic [D-1:0] wr_addr, trig_addr;
  logic [7:0] wr_data;
  logic       busy, ready, forced;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [D+7:0] exp_q[$];   // expected {wr_addr, wr_data}
  logic [D:0]   rec_q[$];   // expected {trig_addr, forced} at ready rise
  logic [D-1:0] exp_addr = '0;
  logic         ready_d = 1'b0;

  acq_ctrl #(.DEPTH_LOG2(D), .PRE_DEPTH(4), .AUTO_TICKS(8)) dut (
    .in_clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .adc_data(adc_data),
    .tb_sel(tb_sel), .arm(arm), .stop(stop), .single(single), .auto_mode(auto_mode),
    .trig_level(trig_level), .trig_rising(trig_rising), .disp_ack(disp_ack),
    .divisor(divisor), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .busy(busy), .ready(ready), .forced(forced),
    .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every wr_en pulse must match the next expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        check("write", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  // Record monitor: each rising ready must carry the expected trigger record.
  always @(negedge clk) begin
    if (ready && !ready_d) begin
      if (rec_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got trig_addr 0x%0h forced %0b, none expected",
                 trig_addr, forced);
      end else begin
        check("record", {trig_addr, forced}, rec_q.pop_front());
      end
    end
    ready_d = ready;
  end

  // One sample strobe, then idle until the next 5-cycle slot.
  task automatic tick(input logic [7:0] d, input bit expect_wr);
    @(negedge clk);
    sample_tick = 1'b1;
    adc_data    = d;
    if (expect_wr) begin
      exp_q.push_back({exp_addr, d});
      exp_addr++;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_arm();
    exp_addr = '0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_trig_addr"}, trig_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_forced"}, forced, 0);
    check({tag, "_divisor"}, divisor, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // Ramp capture 0x60+4i: crosses 0x80 at index 8, READY after index 19.
  task automatic ramp_capture(input bit retime_in_post);
    for (int i = 0; i < 20; i++) begin
      tick(8'(8'h60 + 4 * i), 1'b1);
      if (i == 3) check("ramp_armed", state_dbg, ST_ARMED);
      if (i == 8) begin
        check("ramp_post", state_dbg, ST_POST);
        check("ramp_trig_addr", trig_addr, 8);
        check("ramp_forced", forced, 0);
        if (retime_in_post) tb_sel = 2'd3;
      end
      if (i == 18) check("ramp_not_ready", ready, 0);
    end
    check("ramp_ready", ready, 1);
    check("ramp_busy", busy, 0);
    check("ramp_state", state_dbg, ST_READY);
  endtask

  initial begin
    // Reset state.
    tb_sel = 2'd2;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("div_follow_2", divisor, 2);
    tb_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("div_follow_0", divisor, 0);

    // Rising trigger, single mode.
    single = 1'b1; auto_mode = 1'b0; trig_level = 8'h80; trig_rising = 1'b1;
    rec_q.push_back({4'd8, 1'b0});
    do_arm();
    check("arm_state", state_dbg, ST_PRE);
    check("arm_busy", busy, 1);
    ramp_capture(1'b0);
    tick(8'h44, 1'b0);                   // READY ignores ticks
    do_ack();
    check("ack_idle", state_dbg, ST_IDLE);
    check("ack_ready_low", ready, 0);

    // Auto trigger on the 9th ARMED tick.
    auto_mode = 1'b1;
    rec_q.push_back({4'd12, 1'b1});
    do_arm();
    for (int i = 0; i < 24; i++) begin
      tick(8'h10, 1'b1);
      if (i == 11) check("auto_still_armed", state_dbg, ST_ARMED);
      if (i == 12) begin
        check("auto_post", state_dbg, ST_POST);
        check("auto_forced", forced, 1);
        check("auto_trig_addr", trig_addr, 12);
      end
      if (i == 22) check("auto_not_ready", ready, 0);
    end
    check("auto_ready", ready, 1);
    do_ack();

    // Normal mode: wraps indefinitely without a trigger.
    auto_mode = 1'b0;
    do_arm();
    check("arm_clears_forced", forced, 0);
    for (int i = 0; i < 40; i++) begin
      tick(8'h10, 1'b1);
      if (i >= 3 && (i % 6 == 0)) begin
        check("wrap_armed", state_dbg, ST_ARMED);
        check("wrap_ready", ready, 0);
      end
    end
    do_stop();
    check("wrap_stop_idle", state_dbg, ST_IDLE);
    check("wrap_stop_busy", busy, 0);
    check("stop_keeps_trig_addr", trig_addr, 12);

    // Continuous re-arm with timebase hold.
    single = 1'b0; tb_sel = 2'd0;
    repeat (2) @(negedge clk);
    rec_q.push_back({4'd8, 1'b0});
    do_arm();
    ramp_capture(1'b1);
    check("hold_div_post", divisor, 0);
    single = 1'b1;                       // next hand-off returns to IDLE
    @(negedge clk); disp_ack = 1'b0;
    exp_addr = '0;
    rec_q.push_back({4'd8, 1'b0});
    // disp_ack here uses the single value at its edge, so re-arm needs single=0.
    single = 1'b0;
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0; single = 1'b1;
    check("rearm_pre", state_dbg, ST_PRE);
    check("rearm_ready_low", ready, 0);
    check("rearm_busy", busy, 1);
    check("rearm_div_hold", divisor, 0);
    ramp_capture(1'b0);
    check("hold_div_ready", divisor, 0);
    do_ack();
    check("single_idle", state_dbg, ST_IDLE);
    @(negedge clk);
    check("div_after_idle", divisor, 3);

    // Abort: stop with arm and a tick in the same cycle during POST.
    tb_sel = 2'd0;
    do_arm();
    for (int i = 0; i < 11; i++) tick(8'(8'h60 + 4 * i), 1'b1);
    check("abort_in_post", state_dbg, ST_POST);
    @(negedge clk);
    stop = 1'b1; arm = 1'b1; sample_tick = 1'b1; adc_data = 8'h55;
    @(negedge clk);
    stop = 1'b0; arm = 1'b0; sample_tick = 1'b0;
    check("abort_idle", state_dbg, ST_IDLE);
    check("abort_ready", ready, 0);
    check("abort_wr_en", wr_en, 0);
    for (int i = 0; i < 3; i++) tick(8'h22, 1'b0);
    check("abort_keeps_trig", trig_addr, 8);
    check("abort_keeps_forced", forced, 0);

    // Fresh capture starts at address 0; reset it mid-ARMED.
    do_arm();
    for (int i = 0; i < 6; i++) tick(8'h10, 1'b1);
    check("pre_reset_armed", state_dbg, ST_ARMED);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("reset_queue_drained", exp_q.size(), 0);
    tick(8'h77, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(8'h66, 1'b0);
    check("post_reset_idle", state_dbg, ST_IDLE);
    do_arm();
    tick(8'h33, 1'b1);
    do_stop();

    repeat (3) @(negedge clk);
    check("write_queue_empty", exp_q.size(), 0);
    check("record_queue_empty", rec_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a broken design cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
